// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory request/response plus the decode-side
// instruction handoff, redirect and stall controls.
interface instr_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        stall_d;
  logic        instr_valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;

  // The fetch queue drives the memory request and the decode handoff.
  modport master (
    output imem_req, imem_addr, instr_valid_d, instr_d, pc_d, pc_plus4_d,
    input  imem_valid, imem_rdata, pc_src, pc_target, stall_d
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid_d, instr_d, pc_d, pc_plus4_d,
    output imem_valid, imem_rdata, pc_src, pc_target, stall_d
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch-side PC generator with one outstanding instruction-memory read and a
// small FIFO that hides memory latency and decode stalls from the pipeline.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  instr_fetch_queue_if.master fq_io
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // IDLE: nothing in flight; BUSY: response will be kept; DROP: response is stale.
  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_BUSY,
    FETCH_DROP
  } fetch_state_e;

  fetch_state_e     state_q,   state_d;
  logic [31:0]      pcf_q,     pcf_d;
  logic [31:0]      req_pc_q,  req_pc_d;
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0] count_q,   count_d;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic             head_valid;
  logic             pop;
  logic             resp;
  logic             push;
  logic             req;
  logic [CNT_W-1:0] occ_after;

  assign head_valid = (count_q != '0);

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pcf_d     = pcf_q;
    req_pc_d  = req_pc_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pop       = head_valid && !fq_io.stall_d;
    resp      = fq_io.imem_valid && (state_q != FETCH_IDLE);
    push      = resp && (state_q == FETCH_BUSY) && !fq_io.pc_src;
    occ_after = count_q - CNT_W'(pop) + CNT_W'(push);
    // Issuing only below DEPTH keeps a slot free for the response in flight.
    req       = rst_ni && !fq_io.pc_src &&
                ((state_q == FETCH_IDLE) || fq_io.imem_valid) &&
                (occ_after < CNT_W'(DEPTH));

    if (fq_io.pc_src) begin
      pcf_d    = fq_io.pc_target;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = ((state_q != FETCH_IDLE) && !fq_io.imem_valid) ? FETCH_DROP
                                                                : FETCH_IDLE;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = occ_after;
      if (req) begin
        pcf_d    = pcf_q + 32'd4;
        req_pc_d = pcf_q;
        state_d  = FETCH_BUSY;
      end else if (resp) begin
        state_d  = FETCH_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= FETCH_IDLE;
      pcf_q    <= RESET_PC;
      req_pc_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pcf_q    <= pcf_d;
      req_pc_q <= req_pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q gates every read, so stale
  // contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= fq_io.imem_rdata;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

  assign fq_io.imem_req      = req;
  assign fq_io.imem_addr     = pcf_q;
  assign fq_io.instr_valid_d = head_valid;
  assign fq_io.instr_d       = head_valid ? instr_mem[rd_ptr_q] : NOP;
  assign fq_io.pc_d          = head_valid ? pc_mem[rd_ptr_q] : 32'd0;
  assign fq_io.pc_plus4_d    = head_valid ? pc_mem[rd_ptr_q] + 32'd4 : 32'd0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a vector table for streaming and stall
// behaviour, plus hand-written sequences for redirect, reset and wrap cases.
module tb_instr_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_queue_if fq ();

  instr_fetch_queue #(
    .DEPTH   (4),
    .RESET_PC(32'h0000_0000),
    .NOP     (NOP)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .fq_io (fq)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] d;
    logic        src;
    logic [31:0] tgt;
    logic        stl;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic v, input logic [31:0] d,
                              input logic src, input logic [31:0] tgt, input logic stl,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_instr);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.src = src; r.tgt = tgt; r.stl = stl;
    r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid;
    r.e_pc = e_pc; r.e_instr = e_instr;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge; return at the falling edge.
  task automatic cyc(input logic rst, input logic v, input logic [31:0] d,
                     input logic src, input logic [31:0] tgt, input logic stl);
    @(posedge clk);
    #1;
    rst_n         = ~rst;
    fq.imem_valid = v;
    fq.imem_rdata = d;
    fq.pc_src     = src;
    fq.pc_target  = tgt;
    fq.stall_d    = stl;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_pc,
                            input logic [31:0] e_instr);
    logic [31:0] e_p4;
    e_p4 = e_valid ? e_pc + 32'd4 : 32'd0;
    check({tag, ".req"}, 32'(fq.imem_req), 32'(e_req));
    if (e_req) check({tag, ".addr"}, fq.imem_addr, e_addr);
    check({tag, ".valid"}, 32'(fq.instr_valid_d), 32'(e_valid));
    check({tag, ".pc"}, fq.pc_d, e_pc);
    check({tag, ".instr"}, fq.instr_d, e_instr);
    check({tag, ".pc4"}, fq.pc_plus4_d, e_p4);
  endtask

  initial begin
    fq.imem_valid = 1'b0;
    fq.imem_rdata = '0;
    fq.pc_src     = 1'b0;
    fq.pc_target  = '0;
    fq.stall_d    = 1'b0;

    // Streaming at latency 1, no stall.
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 0,  0, 32'h00, 0, 32'h00, NOP));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0,  1, 32'h00, 0, 32'h00, NOP));
    vecs.push_back(mk(0, 1, 32'hC0DE_0000, 0, 0, 0,  1, 32'h04, 0, 32'h00, NOP));
    vecs.push_back(mk(0, 1, 32'hC0DE_0004, 0, 0, 0,  1, 32'h08, 1, 32'h00, 32'hC0DE_0000));
    vecs.push_back(mk(0, 1, 32'hC0DE_0008, 0, 0, 0,  1, 32'h0C, 1, 32'h04, 32'hC0DE_0004));
    vecs.push_back(mk(0, 1, 32'hC0DE_000C, 0, 0, 0,  1, 32'h10, 1, 32'h08, 32'hC0DE_0008));
    vecs.push_back(mk(0, 1, 32'hC0DE_0010, 0, 0, 0,  1, 32'h14, 1, 32'h0C, 32'hC0DE_000C));
    vecs.push_back(mk(0, 1, 32'hC0DE_0014, 0, 0, 0,  1, 32'h18, 1, 32'h10, 32'hC0DE_0010));
    // Stall for 10 cycles: fills to DEPTH, holds head, then drains in order.
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 0,  0, 32'h00, 0, 32'h00, NOP));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1,  1, 32'h00, 0, 32'h00, NOP));
    vecs.push_back(mk(0, 1, 32'hC0DE_0000, 0, 0, 1,  1, 32'h04, 0, 32'h00, NOP));
    vecs.push_back(mk(0, 1, 32'hC0DE_0004, 0, 0, 1,  1, 32'h08, 1, 32'h00, 32'hC0DE_0000));
    vecs.push_back(mk(0, 1, 32'hC0DE_0008, 0, 0, 1,  1, 32'h0C, 1, 32'h00, 32'hC0DE_0000));
    vecs.push_back(mk(0, 1, 32'hC0DE_000C, 0, 0, 1,  0, 32'h00, 1, 32'h00, 32'hC0DE_0000));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 32'h0,       0, 0, 1,  0, 32'h00, 1, 32'h00, 32'hC0DE_0000));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0,  1, 32'h10, 1, 32'h00, 32'hC0DE_0000));
    vecs.push_back(mk(0, 1, 32'hC0DE_0010, 0, 0, 0,  1, 32'h14, 1, 32'h04, 32'hC0DE_0004));
    vecs.push_back(mk(0, 1, 32'hC0DE_0014, 0, 0, 0,  1, 32'h18, 1, 32'h08, 32'hC0DE_0008));
    vecs.push_back(mk(0, 1, 32'hC0DE_0018, 0, 0, 0,  1, 32'h1C, 1, 32'h0C, 32'hC0DE_000C));
    vecs.push_back(mk(0, 1, 32'hC0DE_001C, 0, 0, 0,  1, 32'h20, 1, 32'h10, 32'hC0DE_0010));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].src, vecs[i].tgt, vecs[i].stl);
      expect_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                 vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr);
    end

    // Latency 3, redirect while the 0x8 request is in flight: its response is dropped.
    cyc(1, 0, 32'h0, 0, 0, 0);                 expect_out("rd.rst", 0, 0, 0, 0, NOP);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("rd.t0",  1, 32'h0, 0, 0, NOP);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("rd.t1",  0, 0, 0, 0, NOP);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("rd.t2",  0, 0, 0, 0, NOP);
    cyc(0, 1, 32'hC0DE_0000, 0, 0, 0);         expect_out("rd.t3",  1, 32'h4, 0, 0, NOP);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("rd.t4",  0, 0, 1, 32'h0, 32'hC0DE_0000);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("rd.t5",  0, 0, 0, 0, NOP);
    cyc(0, 1, 32'hC0DE_0004, 0, 0, 0);         expect_out("rd.t6",  1, 32'h8, 0, 0, NOP);
    cyc(0, 0, 32'h0, 1, 32'h100, 0);           expect_out("rd.t7",  0, 0, 1, 32'h4, 32'hC0DE_0004);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("rd.t8",  0, 0, 0, 0, NOP);
    cyc(0, 1, 32'hDEAD_0008, 0, 0, 0);         expect_out("rd.t9",  1, 32'h100, 0, 0, NOP);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("rd.t10", 0, 0, 0, 0, NOP);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("rd.t11", 0, 0, 0, 0, NOP);
    cyc(0, 1, 32'hC0DE_0100, 0, 0, 0);         expect_out("rd.t12", 1, 32'h104, 0, 0, NOP);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("rd.t13", 0, 0, 1, 32'h100, 32'hC0DE_0100);

    // Redirect coinciding with a response and a stall: data discarded, FIFO flushed.
    cyc(1, 0, 32'h0, 0, 0, 0);                 expect_out("rs.rst", 0, 0, 0, 0, NOP);
    cyc(0, 0, 32'h0, 0, 0, 1);                 expect_out("rs.t0",  1, 32'h0, 0, 0, NOP);
    cyc(0, 1, 32'hC0DE_0000, 0, 0, 1);         expect_out("rs.t1",  1, 32'h4, 0, 0, NOP);
    cyc(0, 1, 32'hC0DE_0004, 1, 32'h40, 1);    expect_out("rs.t2",  0, 0, 1, 32'h0, 32'hC0DE_0000);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("rs.t3",  1, 32'h40, 0, 0, NOP);
    cyc(0, 1, 32'hC0DE_0040, 0, 0, 0);         expect_out("rs.t4",  1, 32'h44, 0, 0, NOP);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("rs.t5",  0, 0, 1, 32'h40, 32'hC0DE_0040);

    // Reset while a request is outstanding; the late response must be ignored.
    cyc(1, 0, 32'h0, 0, 0, 0);                 expect_out("mr.rst0", 0, 0, 0, 0, NOP);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("mr.t0",  1, 32'h0, 0, 0, NOP);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("mr.t1",  0, 0, 0, 0, NOP);
    cyc(1, 0, 32'h0, 0, 0, 0);                 expect_out("mr.rst1", 0, 0, 0, 0, NOP);
    cyc(0, 1, 32'hDEAD_0000, 0, 0, 0);         expect_out("mr.t3",  1, 32'h0, 0, 0, NOP);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("mr.t4",  0, 0, 0, 0, NOP);
    cyc(0, 1, 32'hC0DE_0000, 0, 0, 0);         expect_out("mr.t5",  1, 32'h4, 0, 0, NOP);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("mr.t6",  0, 0, 1, 32'h0, 32'hC0DE_0000);

    // Redirect to the top word: PC and PC+4 wrap to zero.
    cyc(1, 0, 32'h0, 0, 0, 0);                 expect_out("wr.rst", 0, 0, 0, 0, NOP);
    cyc(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0);     expect_out("wr.t0",  0, 0, 0, 0, NOP);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("wr.t1",  1, 32'hFFFF_FFFC, 0, 0, NOP);
    cyc(0, 1, 32'hC0DE_FFFC, 0, 0, 0);         expect_out("wr.t2",  1, 32'h0, 0, 0, NOP);
    cyc(0, 1, 32'hC0DE_0000, 0, 0, 0);         expect_out("wr.t3",  1, 32'h4, 1, 32'hFFFF_FFFC, 32'hC0DE_FFFC);
    check("wr.pc4_wrap", fq.pc_plus4_d, 32'h0000_0000);
    cyc(0, 0, 32'h0, 0, 0, 0);                 expect_out("wr.t4",  0, 0, 1, 32'h0, 32'hC0DE_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
